// File: rtl/sprite_mover.sv
// Moves one sprite over a GRID_W x GRID_H tile grid, checking a maze ROM before each step.
// Latency: step committed 3 cycles after the step event (5 when a buffered turn is blocked).
// Backpressure: none; step events arriving while busy are dropped and flagged in sticky overrun.
//
// Ports: clock/reset_n (async active-low), tick (frame enable), dir_in (turn request, 4..7 = none),
// wall_q (ROM data for qx/qy, one-cycle latency), qx/qy (ROM query), x/y (tile position),
// dir_out (facing), moving, frame_idx ({dir_out, anim}), step_done (commit pulse), overrun (sticky).
module sprite_mover #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int GRID_W   = 27,
    parameter int GRID_H   = 24,
    parameter int START_X  = 13,
    parameter int START_Y  = 17,
    parameter int STEP_DIV = 4,
    parameter int WRAP     = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           tick,
    input  logic [2:0]     dir_in,
    input  logic           wall_q,
    output logic [X_W-1:0] qx,
    output logic [Y_W-1:0] qy,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     dir_out,
    output logic           moving,
    output logic [2:0]     frame_idx,
    output logic           step_done,
    output logic           overrun
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [X_W-1:0]   XMAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   YMAX     = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   X0       = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y0       = Y_W'(START_Y);

    typedef enum logic [2:0] {IDLE, ISSUE_T, CHK_T, ISSUE_F, CHK_F} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             pend_v;
    logic [1:0]       pend_dir;
    logic [1:0]       q_dir;      // direction of the query in flight
    logic             q_off;      // query fell off-grid (WRAP=0): treat as wall
    logic             anim;
    logic             step_evt;
    logic             wall_eff;

    logic             ld_q;
    logic [1:0]       ld_dir;
    logic             commit_t, commit_f, block_f;
    logic [X_W+Y_W:0] nb_res;
    logic             nb_off;
    logic [X_W-1:0]   nb_x;
    logic [Y_W-1:0]   nb_y;

    // Bounds are compared before the +/-1 so nothing ever overflows.
    function automatic logic [X_W+Y_W:0] nbr(input logic [1:0] d,
                                             input logic [X_W-1:0] cx,
                                             input logic [Y_W-1:0] cy);
        logic [X_W-1:0] nx;
        logic [Y_W-1:0] ny;
        logic           off;
        nx  = cx;
        ny  = cy;
        off = 1'b0;
        case (d)
            2'd0: if (cx == XMAX) begin nx = '0;   off = (WRAP == 0); end else nx = cx + 1'b1;
            2'd1: if (cy == '0)   begin ny = YMAX; off = (WRAP == 0); end else ny = cy - 1'b1;
            2'd2: if (cx == '0)   begin nx = XMAX; off = (WRAP == 0); end else nx = cx - 1'b1;
            default: if (cy == YMAX) begin ny = '0; off = (WRAP == 0); end else ny = cy + 1'b1;
        endcase
        return {off, nx, ny};
    endfunction

    assign step_evt  = tick && (div_cnt == DIV_LAST);
    assign wall_eff  = wall_q | q_off;
    assign frame_idx = {dir_out, anim};

    assign nb_res = nbr(ld_dir, x, y);
    assign nb_off = nb_res[X_W+Y_W];
    assign nb_x   = nb_res[X_W+Y_W-1:Y_W];
    assign nb_y   = nb_res[Y_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_q      = 1'b0;
        ld_dir    = 2'd0;
        commit_t  = 1'b0;
        commit_f  = 1'b0;
        block_f   = 1'b0;
        case (state)
            IDLE: begin
                if (step_evt) begin
                    if (pend_v) begin
                        ld_q      = 1'b1;
                        ld_dir    = pend_dir;
                        state_nxt = ISSUE_T;
                    end else if (moving) begin
                        ld_q      = 1'b1;
                        ld_dir    = dir_out;
                        state_nxt = ISSUE_F;
                    end
                end
            end
            ISSUE_T: state_nxt = CHK_T;
            CHK_T: begin
                if (!wall_eff) begin
                    commit_t  = 1'b1;
                    state_nxt = IDLE;
                end else if (moving) begin
                    // Turn blocked: fall back to continuing straight.
                    ld_q      = 1'b1;
                    ld_dir    = dir_out;
                    state_nxt = ISSUE_F;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE_F: state_nxt = CHK_F;
            CHK_F: begin
                commit_f  = !wall_eff;
                block_f   = wall_eff;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            pend_v    <= 1'b0;
            pend_dir  <= 2'd0;
            q_dir     <= 2'd0;
            q_off     <= 1'b0;
            qx        <= X0;
            qy        <= Y0;
            x         <= X0;
            y         <= Y0;
            dir_out   <= 2'd0;
            moving    <= 1'b0;
            anim      <= 1'b0;
            step_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            step_done <= commit_t | commit_f;
            if (tick) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (step_evt && state != IDLE) overrun <= 1'b1;
            if (ld_q) begin
                q_off <= nb_off;
                q_dir <= ld_dir;
                if (!nb_off) begin
                    qx <= nb_x;
                    qy <= nb_y;
                end
            end
            // qx/qy hold the checked neighbour, so a commit just copies them.
            if (commit_t || commit_f) begin
                x    <= qx;
                y    <= qy;
                anim <= ~anim;
            end
            if (commit_t) begin
                dir_out <= q_dir;
                moving  <= 1'b1;
                pend_v  <= 1'b0;
            end
            if (block_f) begin
                moving <= 1'b0;
                anim   <= 1'b0;
            end
            // A fresh request outranks the clear on adoption.
            if (!dir_in[2]) begin
                pend_v   <= 1'b1;
                pend_dir <= dir_in[1:0];
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
module tb_sprite_mover;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  fr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: defaults (STEP_DIV=4, WRAP=1, start 13/17)
    logic       tick_a = 0;
    logic [2:0] dir_in_a = 3'd4;
    logic       wall_q_a = 0;
    logic [7:0] qx_a, x_a;
    logic [6:0] qy_a, y_a;
    logic [1:0] dir_out_a;
    logic       moving_a, step_done_a, overrun_a;
    logic [2:0] frame_a;

    sprite_mover dut_a (
        .clock(clock), .reset_n(reset_n), .tick(tick_a), .dir_in(dir_in_a), .wall_q(wall_q_a),
        .qx(qx_a), .qy(qy_a), .x(x_a), .y(y_a), .dir_out(dir_out_a), .moving(moving_a),
        .frame_idx(frame_a), .step_done(step_done_a), .overrun(overrun_a)
    );

    // Instance B: WRAP=0, STEP_DIV=1, start near right edge
    logic       tick_b = 0;
    logic [2:0] dir_in_b = 3'd4;
    logic       wall_q_b = 0;
    logic [7:0] qx_b, x_b;
    logic [6:0] qy_b, y_b;
    logic [1:0] dir_out_b;
    logic       moving_b, step_done_b, overrun_b;
    logic [2:0] frame_b;

    sprite_mover #(.START_X(25), .START_Y(5), .STEP_DIV(1), .WRAP(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .tick(tick_b), .dir_in(dir_in_b), .wall_q(wall_q_b),
        .qx(qx_b), .qy(qy_b), .x(x_b), .y(y_b), .dir_out(dir_out_b), .moving(moving_b),
        .frame_idx(frame_b), .step_done(step_done_b), .overrun(overrun_b)
    );

    // Maze ROM for A: one-cycle read latency, optional wall row.
    logic       wall_en = 0;
    logic [6:0] wall_row = 0;
    always @(posedge clock) wall_q_a <= wall_en && (qy_a == wall_row);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every step_done must match the oldest expected commit.
    always @(negedge clock) begin
        exp_t e;
        if (step_done_a === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_step_done", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_commit_cycle", cyc, e.cyc);
                check("a_x", {24'd0, x_a}, {24'd0, e.x});
                check("a_y", {25'd0, y_a}, {25'd0, e.y});
                check("a_dir_out", {30'd0, dir_out_a}, {30'd0, e.fr[2:1]});
                check("a_frame", {29'd0, frame_a}, {29'd0, e.fr});
            end
        end
        if (step_done_b === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_step_done", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_commit_cycle", cyc, e.cyc);
                check("b_x", {24'd0, x_b}, {24'd0, e.x});
                check("b_y", {25'd0, y_b}, {25'd0, e.y});
                check("b_frame", {29'd0, frame_b}, {29'd0, e.fr});
            end
        end
    end

    task automatic req_a(input logic [2:0] d);
        @(negedge clock); dir_in_a = d;
        @(negedge clock); dir_in_a = 3'd4;
    endtask

    task automatic req_b(input logic [2:0] d);
        @(negedge clock); dir_in_b = d;
        @(negedge clock); dir_in_b = 3'd4;
    endtask

    // Three spaced ticks, then the fourth (step event) tick in cycle N.
    task automatic pre_ticks_a();
        repeat (3) begin
            @(negedge clock); tick_a = 1;
            @(negedge clock); tick_a = 0;
            repeat (4) @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic step_a(input bit push, input int lat, input logic [7:0] ex,
                          input logic [6:0] ey, input logic [2:0] efr);
        exp_t e;
        pre_ticks_a();
        tick_a = 1;
        if (push) begin
            e.cyc = cyc + lat; e.x = ex; e.y = ey; e.fr = efr;
            qa.push_back(e);
        end
        @(negedge clock); tick_a = 0;
        repeat (8) @(negedge clock);
        check("a_scoreboard_drained", qa.size(), 0);
    endtask

    task automatic pulse_b(input bit push, input int lat, input logic [7:0] ex,
                           input logic [6:0] ey, input logic [2:0] efr);
        exp_t e;
        @(negedge clock); tick_b = 1;
        if (push) begin
            e.cyc = cyc + lat; e.x = ex; e.y = ey; e.fr = efr;
            qb.push_back(e);
        end
        @(negedge clock); tick_b = 0;
        repeat (6) @(negedge clock);
    endtask

    logic anim_a = 0;
    logic anim_b = 0;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_x", {24'd0, x_a}, 13);
        check("rst_y", {25'd0, y_a}, 17);
        check("rst_qx", {24'd0, qx_a}, 13);
        check("rst_qy", {25'd0, qy_a}, 17);
        check("rst_frame", {29'd0, frame_a}, 0);
        check("rst_moving", {31'd0, moving_a}, 0);
        check("rst_step_done", {31'd0, step_done_a}, 0);
        check("rst_overrun", {31'd0, overrun_a}, 0);
        check("rst_b_x", {24'd0, x_b}, 25);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // No requests: eight step events, sprite stays put.
        repeat (8) step_a(0, 0, 0, 0, 0);
        check("idle_x", {24'd0, x_a}, 13);
        check("idle_y", {25'd0, y_a}, 17);
        check("idle_moving", {31'd0, moving_a}, 0);
        check("idle_frame", {29'd0, frame_a}, 0);

        // Request right once, then keep moving through the tunnel wrap.
        req_a(3'd0);
        for (int i = 14; i <= 27; i++) begin
            anim_a = ~anim_a;
            step_a(1, 3, (i == 27) ? 8'd0 : 8'(i), 7'd17, {2'd0, anim_a});
        end
        check("wrap_x", {24'd0, x_a}, 0);
        check("wrap_moving", {31'd0, moving_a}, 1);

        // Turn up blocked by wall row 16: forward move at T+5.
        wall_en = 1; wall_row = 7'd16;
        req_a(3'd1);
        anim_a = ~anim_a;
        step_a(1, 5, 8'd1, 7'd17, {2'd0, anim_a});
        // Wall opens: still-pending turn commits at T+3.
        wall_en = 0;
        anim_a = ~anim_a;
        step_a(1, 3, 8'd1, 7'd16, {2'd1, anim_a});

        // Forward blocked: stop, anim cleared, no step_done.
        wall_en = 1; wall_row = 7'd15;
        step_a(0, 0, 0, 0, 0);
        anim_a = 0;
        check("blk_moving", {31'd0, moving_a}, 0);
        check("blk_frame", {29'd0, frame_a}, {29'd0, 2'd1, 1'b0});
        check("blk_y", {25'd0, y_a}, 16);
        step_a(0, 0, 0, 0, 0);
        check("stopped_x", {24'd0, x_a}, 1);

        // Instance B: WRAP=0 edge.
        req_b(3'd0);
        anim_b = ~anim_b;
        pulse_b(1, 3, 8'd26, 7'd5, {2'd0, anim_b});
        pulse_b(0, 0, 0, 0, 0);
        anim_b = 0;
        repeat (2) @(negedge clock);
        check("b_edge_x", {24'd0, x_b}, 26);
        check("b_edge_qx", {24'd0, qx_b}, 26);
        check("b_edge_moving", {31'd0, moving_b}, 0);
        check("b_edge_frame", {29'd0, frame_b}, 0);
        check("b_scoreboard_drained", qb.size(), 0);
        check("b_overrun_clear", {31'd0, overrun_b}, 0);

        // Overrun: second step event two cycles after the first.
        req_b(3'd2);
        @(negedge clock); tick_b = 1;
        begin
            exp_t e;
            anim_b = ~anim_b;
            e.cyc = cyc + 3; e.x = 8'd25; e.y = 7'd5; e.fr = {2'd2, anim_b};
            qb.push_back(e);
        end
        @(negedge clock); tick_b = 0;
        @(negedge clock); tick_b = 1;
        @(negedge clock); tick_b = 0;
        repeat (8) @(negedge clock);
        check("b_overrun_set", {31'd0, overrun_b}, 1);
        anim_b = ~anim_b;
        pulse_b(1, 3, 8'd24, 7'd5, {2'd2, anim_b});
        check("b_overrun_sticky", {31'd0, overrun_b}, 1);
        check("b_scoreboard_drained2", qb.size(), 0);

        // Async reset while A sits in CHK_F with an open path.
        wall_en = 0;
        req_a(3'd0);
        anim_a = ~anim_a;
        step_a(1, 3, 8'd2, 7'd16, {2'd0, anim_a});
        pre_ticks_a();
        tick_a = 1;
        @(negedge clock); tick_a = 0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst_x", {24'd0, x_a}, 13);
        check("arst_y", {25'd0, y_a}, 17);
        check("arst_moving", {31'd0, moving_a}, 0);
        check("arst_frame", {29'd0, frame_a}, 0);
        check("arst_b_overrun", {31'd0, overrun_b}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("arst_x_hold", {24'd0, x_a}, 13);
        check("arst_step_done", {31'd0, step_done_a}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
